// File: rtl/clkdiv_seq_ctrl.sv
// clkdiv_seq_ctrl: plays a table of (divide, toggle-count) segments onto a divided clock.
// Rev 1.0
`default_nettype none

module clkdiv_seq_ctrl #(
    parameter int DIV_W  = 16,
    parameter int REP_W  = 4,
    parameter int SEG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_wr,
    input  logic [SEG_AW-1:0] cfg_addr,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [REP_W-1:0]  cfg_rep,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic              div_clk,
    output logic              tick,
    output logic              busy,
    output logic              done,
    output logic [SEG_AW-1:0] seg_idx,
    output logic              cfg_err
);

    localparam int                N_SEG    = 2 ** SEG_AW;
    localparam logic [SEG_AW-1:0] LAST_SEG = SEG_AW'(N_SEG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   tbl_div [N_SEG];
    logic [REP_W-1:0]   tbl_rep [N_SEG];
    logic [DIV_W-1:0]   counter, counter_nxt;
    logic [REP_W-1:0]   rem, rem_nxt;
    logic [SEG_AW-1:0]  seg_nxt;
    logic [SEG_AW-1:0]  seg_inc;
    logic               div_clk_nxt;
    logic               tick_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic               busy_nxt;
    logic               tbl_we;
    logic               advance;

    assign seg_inc = seg_idx + SEG_AW'(1);

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        rem_nxt     = rem;
        seg_nxt     = seg_idx;
        div_clk_nxt = div_clk;
        tick_nxt    = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        tbl_we      = 1'b0;
        advance     = 1'b0;

        case (state)
            IDLE: begin
                tbl_we = cfg_wr;
                if (start && !stop) begin
                    state_nxt   = RUN;
                    seg_nxt     = '0;
                    counter_nxt = '0;
                    rem_nxt     = tbl_rep[0];
                end
            end
            RUN: begin
                err_nxt = cfg_wr;
                if (stop) begin
                    state_nxt   = IDLE;
                    div_clk_nxt = 1'b0;
                    counter_nxt = '0;
                    seg_nxt     = '0;
                end else begin
                    if (rem == '0) begin
                        advance = 1'b1;
                    end else if (counter == tbl_div[seg_idx]) begin
                        counter_nxt = '0;
                        div_clk_nxt = ~div_clk;
                        tick_nxt    = 1'b1;
                        if (rem == REP_W'(1)) begin
                            advance = 1'b1;
                        end else begin
                            rem_nxt = rem - REP_W'(1);
                        end
                    end else begin
                        counter_nxt = counter + DIV_W'(1);
                    end

                    // div_clk keeps its phase across segment boundaries
                    if (advance) begin
                        counter_nxt = '0;
                        if (seg_idx != LAST_SEG) begin
                            seg_nxt = seg_inc;
                            rem_nxt = tbl_rep[seg_inc];
                        end else if (loop_en) begin
                            seg_nxt = '0;
                            rem_nxt = tbl_rep[0];
                        end else begin
                            state_nxt   = DONE;
                            done_nxt    = 1'b1;
                            div_clk_nxt = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                err_nxt   = cfg_wr;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            rem     <= '0;
            seg_idx <= '0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            busy    <= 1'b0;
        end else if (ena) begin
            state   <= state_nxt;
            counter <= counter_nxt;
            rem     <= rem_nxt;
            seg_idx <= seg_nxt;
            div_clk <= div_clk_nxt;
            tick    <= tick_nxt;
            done    <= done_nxt;
            cfg_err <= err_nxt;
            busy    <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SEG; i++) begin
                tbl_div[i] <= '0;
                tbl_rep[i] <= '0;
            end
        end else if (ena && tbl_we) begin
            tbl_div[cfg_addr] <= cfg_div;
            tbl_rep[cfg_addr] <= cfg_rep;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_seq_ctrl.sv
// tb_clkdiv_seq_ctrl: directed bench for the segment sequencer with hand-computed traces.
// Rev 1.0
`default_nettype none

module tb_clkdiv_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_rep;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        div_clk;
    logic        tick;
    logic        busy;
    logic        done;
    logic [1:0]  seg_idx;
    logic        cfg_err;

    int n_chk  = 0;
    int n_fail = 0;

    // bit i of each log = output value sampled just after edge i of a playback
    logic [31:0] lt, ld, lb, lc, ls0, ls1, le;

    clkdiv_seq_ctrl #(.DIV_W(16), .REP_W(4), .SEG_AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .cfg_wr   (cfg_wr),
        .cfg_addr (cfg_addr),
        .cfg_div  (cfg_div),
        .cfg_rep  (cfg_rep),
        .loop_en  (loop_en),
        .start    (start),
        .stop     (stop),
        .div_clk  (div_clk),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .seg_idx  (seg_idx),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [3:0] r);
        cfg_addr = a;
        cfg_div  = d;
        cfg_rep  = r;
        cfg_wr   = 1'b1;
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_log(input int n, input int wr_at, input int st_at,
                           input int ena_lo_from, input int ena_lo_to);
        lt = '0; ld = '0; lb = '0; lc = '0; ls0 = '0; ls1 = '0; le = '0;
        for (int i = 1; i <= n; i++) begin
            cfg_wr = (i == wr_at);
            start  = (i == st_at);
            ena    = !(i >= ena_lo_from && i <= ena_lo_to);
            step();
            lt[i]  = tick;
            ld[i]  = done;
            lb[i]  = busy;
            lc[i]  = div_clk;
            ls0[i] = (seg_idx == 2'd0);
            ls1[i] = (seg_idx == 2'd1);
            le[i]  = cfg_err;
        end
        cfg_wr = 1'b0;
        start  = 1'b0;
        ena    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_div = '0;
        cfg_rep = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, busy, tick, div_clk, done, cfg_err, 1'b0, seg_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // single segment, three toggles, then three skips
        wr(2'd0, 16'd2, 4'd3);
        wr(2'd1, 16'd0, 4'd0);
        wr(2'd2, 16'd0, 4'd0);
        wr(2'd3, 16'd0, 4'd0);
        chk("idle_wr_no_err", {31'd0, cfg_err}, 32'd0);
        go();
        chk("t1_busy_on_start", {31'd0, busy}, 32'd1);
        run_log(14, 0, 0, 0, -1);
        chk("t1_ticks", lt, 32'h0000_0208 | 32'h40);
        chk("t1_done", ld, 32'h0000_1000);
        chk("t1_busy", lb, 32'h0000_1FFE);
        chk("t1_div_clk", lc, 32'h0000_0E38);
        chk("t1_seg1", ls1, 32'h0000_0200);

        // two segments at different rates
        wr(2'd0, 16'd1, 4'd2);
        wr(2'd1, 16'd0, 4'd4);
        go();
        run_log(12, 0, 0, 0, -1);
        chk("t2_ticks", lt, 32'h0000_01F4);
        chk("t2_done", ld, 32'h0000_0400);
        chk("t2_seg1", ls1, 32'h0000_00F0);
        chk("t2_busy", lb, 32'h0000_07FE);

        // looping, then abort mid-segment with div_clk high
        loop_en = 1'b1;
        go();
        run_log(22, 0, 0, 0, -1);
        chk("t3_ticks", lt, 32'h0047_D1F4);
        chk("t3_seg0", ls0, 32'h0070_3C0E);
        chk("t3_no_done", ld, 32'h0);
        chk("t3_div_clk_pre_stop", {31'd0, div_clk}, 32'd1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t3_stop_state", {28'd0, busy, div_clk, seg_idx}, 32'd0);
        chk("t3_stop_no_done", {31'd0, done}, 32'd0);
        run_log(4, 0, 0, 0, -1);
        chk("t3_quiet_after_stop", lt | ld | lb, 32'd0);
        loop_en = 1'b0;

        // blocked write and ignored restart while running
        cfg_addr = 2'd0; cfg_div = 16'd5; cfg_rep = 4'd1;
        go();
        run_log(12, 2, 3, 0, -1);
        chk("t4_cfg_err", le, 32'h0000_0004);
        chk("t4_ticks", lt, 32'h0000_01F4);
        chk("t4_done", ld, 32'h0000_0400);
        go();
        run_log(12, 0, 0, 0, -1);
        chk("t4_replay_ticks", lt, 32'h0000_01F4);

        // enable freeze mid-count
        wr(2'd0, 16'd2, 4'd3);
        wr(2'd1, 16'd0, 4'd0);
        go();
        run_log(18, 0, 0, 5, 9);
        chk("t5_ticks", lt, 32'h0000_4808);
        chk("t5_done", ld, 32'h0002_0000);
        chk("t5_div_clk", lc, 32'h0001_C7F8);

        // asynchronous reset mid-run clears outputs and table
        go();
        run_log(3, 0, 0, 0, -1);
        chk("t6_pre_reset_tick", {31'd0, tick}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {26'd0, busy, tick, div_clk, done, cfg_err, 1'b0, seg_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        go();
        run_log(6, 0, 0, 0, -1);
        chk("t6_no_ticks", lt, 32'd0);
        chk("t6_done", ld, 32'h0000_0010);
        chk("t6_busy", lb, 32'h0000_001E);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
